// File: rtl/squash_dial.sv
// Paced dial step generator for the Squash spinner: turns held up/down controls
// into fixed-width step codes separated by idle gaps, with a faster cadence after a run.
module squash_dial #(
  parameter int PULSE_CYC   = 12000,
  parameter int GAP_SLOW    = 48000,
  parameter int GAP_FAST    = 12000,
  parameter int ACCEL_STEPS = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       invert,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] dial,
  output logic       busy
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_SLOW) ? PULSE_CYC : GAP_SLOW;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int SW      = $clog2(ACCEL_STEPS + 1);

  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] SLOW_LD   = CW'(GAP_SLOW - 1);
  localparam logic [CW-1:0] FAST_LD   = CW'(GAP_FAST - 1);
  localparam logic [SW-1:0] STEPS_MAX = SW'(ACCEL_STEPS);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_DOWN, REQ_UP} req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] steps_q, steps_d;
  logic          dir_q, dir_d;      // 1 = up, 0 = down
  logic          inv_q, inv_d;
  logic [1:0]    dial_q, dial_d;
  logic          busy_q, busy_d;
  req_t          req;

  always_comb begin
    req = REQ_NONE;
    if (btn_down && !btn_up)      req = REQ_DOWN;
    else if (btn_up && !btn_down) req = REQ_UP;

    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    inv_d   = inv_q;

    case (state_q)
      IDLE: begin
        if (req != REQ_NONE) begin
          state_d = PULSE;
          dir_d   = (req == REQ_UP);
          inv_d   = invert;
          cnt_d   = PULSE_LD;
          steps_d = STEP_ONE;
        end
      end
      PULSE: begin
        // Inputs are ignored here so a pulse is never shortened.
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = (steps_q == STEPS_MAX) ? FAST_LD : SLOW_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (req == REQ_NONE) begin
          state_d = IDLE;
          steps_d = '0;
        end else begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
          if ((req == REQ_UP) == dir_q) begin
            if (steps_q != STEPS_MAX) steps_d = steps_q + 1'b1;
          end else begin
            dir_d   = (req == REQ_UP);
            inv_d   = invert;
            steps_d = STEP_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      steps_d = '0;
    end

    dial_d = 2'd3;
    if (state_d == PULSE) dial_d = (dir_d ^ inv_d) ? 2'd2 : 2'd1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      steps_q <= '0;
      dir_q   <= 1'b0;
      inv_q   <= 1'b0;
      dial_q  <= 2'd3;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      inv_q   <= inv_d;
      dial_q  <= dial_d;
      busy_q  <= busy_d;
    end
  end

  assign dial = dial_q;
  assign busy = busy_q;

endmodule

// File: doc/squash_dial.md
# squash_dial

Turns digital up/down controls into paced, accelerating dial step pulses for the Squash spinner mode. Sits between the hps_io joystick decode and the `joy_p1`/`joy_p2` bits [6:5] of the bagman core, with one instance per player. It replaces the level-mapped dial with timed pulses of guaranteed minimum width, so the game's dial sampler never misses or merges steps.

## Interface
Parameters:
- PULSE_CYC, 12000 — cycles a step code is held (1 ms at 12 MHz).
- GAP_SLOW, 48000 — idle cycles between steps before acceleration.
- GAP_FAST, 12000 — idle cycles between steps after acceleration.
- ACCEL_STEPS, 8 — consecutive same-direction steps before switching to GAP_FAST.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  spinner mode active (`mod_squa & status[6|7]`).
- invert  in  1  swap direction codes (player 2).
- btn_up  in  1  active-high up control (clk_sys domain).
- btn_down  in  1  active-high down control (clk_sys domain).
- dial  out  2  dial code: 3 = idle, 1 = down step, 2 = up step (before inversion).
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Request decode (combinational):
  - dir_req = DOWN if btn_down & !btn_up.
  - dir_req = UP if btn_up & !btn_down.
  - Otherwise NONE; both pressed counts as NONE.
- State machine IDLE, PULSE, GAP. Registers:
  - cnt: width $clog2(max(PULSE_CYC, GAP_SLOW)) + 1.
  - dir: 1 bit, latched direction.
  - inv_l: 1 bit, latched invert.
  - steps: saturates at ACCEL_STEPS.
- IDLE:
  - dial = 3.
  - If dir_req ≠ NONE: latch dir, latch inv_l = invert, cnt = PULSE_CYC − 1, steps = 1, go to PULSE.
- PULSE:
  - dial = code(dir, inv_l): DOWN → 1, UP → 2; inv_l swaps 1 and 2.
  - cnt decrements. At cnt == 0: load cnt = (steps == ACCEL_STEPS ? GAP_FAST : GAP_SLOW) − 1, go to GAP.
  - Releasing or changing the input during PULSE does not shorten it; pulse width is always exactly PULSE_CYC.
- GAP:
  - dial = 3; cnt decrements.
  - At cnt == 0, per dir_req:
    - NONE → IDLE, steps = 0.
    - Same direction as dir → PULSE, steps = min(steps + 1, ACCEL_STEPS).
    - Opposite direction → PULSE with new dir and inv_l re-latched, steps = 1.
- enable low: synchronously forces IDLE, dial = 3, steps = 0, cnt = 0. This takes effect on the next edge and overrides all other transitions.
- busy = (state ≠ IDLE).

## Timing
- Reset (async, reset_n low) gives: state IDLE, dial = 3, busy = 0, cnt = 0, steps = 0, dir = DOWN, inv_l = 0.
- All outputs are registered; there is no combinational path from inputs to dial.
- Press latency: dir_req asserted before edge N puts the step code on dial after edge N (1 cycle).
- Step period is PULSE_CYC + GAP cycles.
  - The first ACCEL_STEPS − 1 gaps use GAP_SLOW.
  - Every gap after step ACCEL_STEPS uses GAP_FAST.
- After the last GAP, dial stays 3 continuously; code 3 always separates two step codes for at least GAP_FAST cycles.
- Counter loads use value − 1, so a PULSE lasts exactly PULSE_CYC cycles and a GAP exactly its configured gap. Parameters must be ≥ 1.
- Reset deasserting mid-operation leaves the block in IDLE. A button held through reset starts a pulse 1 cycle after the first active edge.

## Test plan
Simulate with PULSE_CYC = 4, GAP_SLOW = 8, GAP_FAST = 2, ACCEL_STEPS = 3, enable = 1.
- Reset then idle: hold reset_n = 0 → dial = 3, busy = 0. Release with no buttons → dial stays 3 for 100 cycles.
- Single tap: btn_down for 1 cycle → dial = 1 for exactly 4 cycles starting 1 cycle later, then 3 for 8 cycles. busy falls on the cycle after the gap ends.
- Hold up for 60 cycles → pulses of dial = 2. Gaps measured between pulses are 8, 8, 2, 2, … cycles.
- Direction reversal: hold down, switch to up mid-PULSE → current pulse completes as 1 (4 cycles), a gap of 8 follows, then dial = 2 with the slow gap restarting (steps reset).
- invert = 1 with btn_down → dial = 2. Toggling invert mid-pulse does not change the current pulse's code.
- Edge cases:
  - Both buttons pressed from IDLE → dial stays 3.
  - enable dropped mid-PULSE → dial = 3 and busy = 0 on the next edge.
  - reset_n pulsed low mid-GAP → immediate async return to the reset values.
